// File: rtl/boost_mode_controller.sv
// boost_mode_controller: timed per-channel hood boost FSM with cancel, OFF override and optional one-shot lockout
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   current_mode      present hood mode code (OFF_CODE / STAND_CODE / other)
//   sec_tick          one-cycle timebase pulse driving the countdown
//   req[NUM_CH]       one-cycle per-channel boost request pulses
//   cancel            one-cycle abort pulse
//   enter_toggle      one-cycle pulse commanding entry into channel i boost
//   exit_toggle       one-cycle pulse commanding return to standby
//   active            one-hot running channel, zero when idle
//   remaining         ticks left in the current boost
//   used              per-channel consumed-this-session flags
//
// Build option: define BOOST_ONE_SHOT_EN to allow each channel only one grant
// per power session (cleared by OFF_CODE or reset).
module boost_mode_controller #(
    parameter int MODE_WIDTH = 3,
    parameter int NUM_CH     = 2,
    parameter int RUN_TICKS  = 60,
    parameter int OFF_CODE   = 0,
    parameter int STAND_CODE = 1,
    parameter int CNT_W      = $clog2(RUN_TICKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MODE_WIDTH-1:0] current_mode,
    input  logic                  sec_tick,
    input  logic [NUM_CH-1:0]     req,
    input  logic                  cancel,
    output logic [NUM_CH-1:0]     enter_toggle,
    output logic                  exit_toggle,
    output logic [NUM_CH-1:0]     active,
    output logic [CNT_W-1:0]      remaining,
    output logic [NUM_CH-1:0]     used
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [MODE_WIDTH-1:0] OFF_M   = MODE_WIDTH'(OFF_CODE);
    localparam logic [MODE_WIDTH-1:0] STAND_M = MODE_WIDTH'(STAND_CODE);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] enter_q, enter_d, active_q, active_d, used_q, used_d;
    logic [NUM_CH-1:0] elig, grant;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              exit_q, exit_d;

    // Isolate the lowest set bit so simultaneous requests go to the lowest index.
    assign elig  = req & ~used_q;
    assign grant = elig & (-elig);

    always_comb begin
        state_d     = state_q;
        enter_d     = '0;
        exit_d      = 1'b0;
        active_d    = active_q;
        remaining_d = remaining_q;
        used_d      = used_q;
        if (current_mode == OFF_M) begin
            state_d     = IDLE;
            active_d    = '0;
            remaining_d = '0;
            used_d      = '0;
        end else if (state_q == IDLE) begin
            if (current_mode == STAND_M && |grant) begin
                state_d     = RUN;
                enter_d     = grant;
                active_d    = grant;
                remaining_d = CNT_W'(RUN_TICKS);
`ifdef BOOST_ONE_SHOT_EN
                used_d      = used_q | grant;
`endif
            end
        end else if (cancel || |(req & active_q) || (sec_tick && remaining_q == CNT_W'(1))) begin
            // Early exit outranks a coincident tick; both end the same way.
            state_d     = IDLE;
            exit_d      = 1'b1;
            active_d    = '0;
            remaining_d = '0;
        end else if (sec_tick) begin
            remaining_d = remaining_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            enter_q     <= '0;
            exit_q      <= 1'b0;
            active_q    <= '0;
            remaining_q <= '0;
            used_q      <= '0;
        end else begin
            state_q     <= state_d;
            enter_q     <= enter_d;
            exit_q      <= exit_d;
            active_q    <= active_d;
            remaining_q <= remaining_d;
            used_q      <= used_d;
        end
    end

    assign enter_toggle = enter_q;
    assign exit_toggle  = exit_q;
    assign active       = active_q;
    assign remaining    = remaining_q;
    assign used         = used_q;
endmodule
